// File: rtl/alu_seq_if.sv
// Request/response bus between the operand latches, alu_seq and the flag/accumulator writeback.
interface alu_seq_if #(
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned SW = $clog2(WIDTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carry_in;
  logic [SW-1:0]    shamt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             half_carry;
  logic             overflow;
  logic             zero;
  logic             negative;

  modport master (
    output in_valid, op, a, b, carry_in, shamt, out_ready,
    input  in_ready, out_valid, result, carry, half_carry, overflow, zero, negative
  );

  modport slave (
    input  in_valid, op, a, b, carry_in, shamt, out_ready,
    output in_ready, out_valid, result, carry, half_carry, overflow, zero, negative
  );
endinterface

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: single-cycle logic/arith/BCD ops, bit-serial shifts.
module alu_seq #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned DECIMAL = 1
) (
  input  logic      clk,
  input  logic      rst,
  alu_seq_if.slave  bus
);
  localparam int unsigned SW  = $clog2(WIDTH + 1);
  localparam int unsigned NIB = WIDTH / 4;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_AND  = 3'b001;
  localparam logic [2:0] OP_OR   = 3'b010;
  localparam logic [2:0] OP_EOR  = 3'b011;
  localparam logic [2:0] OP_SR   = 3'b100;
  localparam logic [2:0] OP_SL   = 3'b101;
  localparam logic [2:0] OP_DADD = 3'b110;
  localparam logic [2:0] OP_SUB  = 3'b111;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [SW-1:0]    cnt;
  logic             fill;
  logic             dir_left;
  logic [WIDTH-1:0] result_q;
  logic             carry_q;
  logic             half_q;
  logic             ovf_q;
  logic             zero_q;
  logic             neg_q;
  logic             out_valid_q;

  logic [SW-1:0]    eff_shamt;
  logic             is_shift;
  logic [WIDTH-1:0] bop;
  logic [WIDTH:0]   sum;
  logic [4:0]       nib0;
  logic [4:0]       ds;
  logic             dc;
  logic             dec_hc;
  logic [WIDTH-1:0] dec_res;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_hc;
  logic             alu_v;
  logic [WIDTH-1:0] step_res;
  logic             step_c;

  assign bus.in_ready   = (state == IDLE);
  assign bus.out_valid  = out_valid_q;
  assign bus.result     = result_q;
  assign bus.carry      = carry_q;
  assign bus.half_carry = half_q;
  assign bus.overflow   = ovf_q;
  assign bus.zero       = zero_q;
  assign bus.negative   = neg_q;

  assign eff_shamt = (bus.shamt > SW'(WIDTH)) ? SW'(WIDTH) : bus.shamt;
  assign is_shift  = (bus.op == OP_SR) || (bus.op == OP_SL);

  // Single-cycle result and flags for the operation presented at the inputs.
  always_comb begin
    bop  = (bus.op == OP_SUB) ? ~bus.b : bus.b;
    sum  = {1'b0, bus.a} + {1'b0, bop} + (WIDTH+1)'(bus.carry_in);
    nib0 = {1'b0, bus.a[3:0]} + {1'b0, bop[3:0]} + 5'(bus.carry_in);

    dec_res = '0;
    dc      = bus.carry_in;
    dec_hc  = 1'b0;
    ds      = '0;
    for (int i = 0; i < int'(NIB); i++) begin
      ds = {1'b0, bus.a[4*i +: 4]} + {1'b0, bus.b[4*i +: 4]} + 5'(dc);
      if (ds > 5'd9) begin
        dec_res[4*i +: 4] = 4'(ds + 5'd6);
        dc = 1'b1;
      end else begin
        dec_res[4*i +: 4] = ds[3:0];
        dc = 1'b0;
      end
      if (i == 0) dec_hc = dc;
    end

    alu_res = '0;
    alu_c   = 1'b0;
    alu_hc  = 1'b0;
    alu_v   = 1'b0;
    case (bus.op)
      OP_ADD, OP_SUB: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_hc  = nib0[4];
        alu_v   = (bus.a[WIDTH-1] == bop[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_DADD: begin
        if (DECIMAL != 0) begin
          alu_res = dec_res;
          alu_c   = dc;
          alu_hc  = dec_hc;
        end else begin
          alu_res = sum[WIDTH-1:0];
          alu_c   = sum[WIDTH];
          alu_hc  = nib0[4];
          alu_v   = (bus.a[WIDTH-1] == bop[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
        end
      end
      OP_AND: alu_res = bus.a & bus.b;
      OP_OR:  alu_res = bus.a | bus.b;
      OP_EOR: alu_res = bus.a ^ bus.b;
      OP_SR, OP_SL: begin
        alu_res = bus.a;
        alu_c   = bus.carry_in;
      end
      default: alu_res = '0;
    endcase
  end

  // One shift step on the held result, using the fill bit latched at accept.
  always_comb begin
    if (dir_left) begin
      step_res = {result_q[WIDTH-2:0], fill};
      step_c   = result_q[WIDTH-1];
    end else begin
      step_res = {fill, result_q[WIDTH-1:1]};
      step_c   = result_q[0];
    end
  end

  // Control FSM with registered result, flags and out_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      fill        <= 1'b0;
      dir_left    <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      half_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            if (is_shift && (eff_shamt != '0)) begin
              result_q <= bus.a;
              cnt      <= eff_shamt;
              fill     <= bus.carry_in;
              dir_left <= (bus.op == OP_SL);
              half_q   <= 1'b0;
              ovf_q    <= 1'b0;
              state    <= SHIFT;
            end else begin
              result_q    <= alu_res;
              carry_q     <= alu_c;
              half_q      <= alu_hc;
              ovf_q       <= alu_v;
              zero_q      <= (alu_res == '0);
              neg_q       <= alu_res[WIDTH-1];
              out_valid_q <= 1'b1;
              state       <= DONE;
            end
          end
        end
        SHIFT: begin
          result_q <= step_res;
          carry_q  <= step_c;
          cnt      <= cnt - SW'(1);
          if (cnt == SW'(1)) begin
            zero_q      <= (step_res == '0);
            neg_q       <= step_res[WIDTH-1];
            out_valid_q <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed test-plan steps plus random ops against an arithmetic model.
module tb_alu_seq;
  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(W)) bus ();
  alu_seq_if #(.WIDTH(W)) bbus ();

  // Binary-only instance shares the stimulus of the decimal one.
  assign bbus.in_valid  = bus.in_valid;
  assign bbus.op        = bus.op;
  assign bbus.a         = bus.a;
  assign bbus.b         = bus.b;
  assign bbus.carry_in  = bus.carry_in;
  assign bbus.shamt     = bus.shamt;
  assign bbus.out_ready = bus.out_ready;

  alu_seq #(.WIDTH(W), .DECIMAL(1)) u_dut (.clk(clk), .rst(rst), .bus(bus));
  alu_seq #(.WIDTH(W), .DECIMAL(0)) u_bin (.clk(clk), .rst(rst), .bus(bbus));

  typedef struct {
    logic [7:0] res;
    logic       c;
    logic       hc;
    logic       v;
    logic       z;
    logic       ng;
  } exp_t;

  // Expected outputs from the arithmetic definition of each op.
  function automatic exp_t model(input int op, input int a, input int b, input int cin,
                                 input int sh, input bit dec);
    exp_t e;
    int   r, s, bb, n, ci, d, sa, sb, ss, o;
    n = (sh > 8) ? 8 : sh;
    o = (op == 6 && !dec) ? 0 : op;
    r = 0; e.c = 0; e.hc = 0; e.v = 0;
    case (o)
      0, 7: begin
        bb   = (o == 7) ? (~b & 255) : b;
        s    = a + bb + cin;
        r    = s & 255;
        e.c  = (s > 255);
        e.hc = ((a & 15) + (bb & 15) + cin) > 15;
        sa   = (a > 127) ? a - 256 : a;
        sb   = (bb > 127) ? bb - 256 : bb;
        ss   = sa + sb + cin;
        e.v  = (ss > 127) || (ss < -128);
      end
      6: begin
        ci = cin;
        for (int i = 0; i < 2; i++) begin
          d = ((a >> (4*i)) & 15) + ((b >> (4*i)) & 15) + ci;
          if (d > 9) begin d = (d + 6) & 15; ci = 1; end
          else ci = 0;
          r = r | (d << (4*i));
          if (i == 0) e.hc = ci[0];
        end
        e.c = ci[0];
      end
      1: r = a & b;
      2: r = a | b;
      3: r = a ^ b;
      4: begin
        if (n == 0) begin r = a; e.c = cin[0]; end
        else begin
          r   = (a >> n) | ((cin != 0) ? ((255 << (8 - n)) & 255) : 0);
          e.c = ((a >> (n - 1)) & 1) != 0;
        end
      end
      default: begin
        if (n == 0) begin r = a; e.c = cin[0]; end
        else begin
          r   = ((a << n) | ((cin != 0) ? ((1 << n) - 1) : 0)) & 255;
          e.c = ((a >> (8 - n)) & 1) != 0;
        end
      end
    endcase
    e.res = 8'(r);
    e.z   = (r == 0);
    e.ng  = ((r >> 7) & 1) != 0;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Full request/response transaction with model checks on both instances.
  task automatic transact(input int op, input int a, input int b, input int cin,
                          input int sh, input int dly);
    exp_t e1, e0;
    int   lat, elat, n;
    e1   = model(op, a, b, cin, sh, 1'b1);
    e0   = model(op, a, b, cin, sh, 1'b0);
    n    = (sh > 8) ? 8 : sh;
    elat = ((op == 4 || op == 5) && n > 0) ? n + 1 : 1;
    @(negedge clk);
    chk("in_ready_idle", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.op       = 3'(op);
    bus.a        = 8'(a);
    bus.b        = 8'(b);
    bus.carry_in = 1'(cin);
    bus.shamt    = 4'(sh);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.op       = 3'($urandom);
    bus.a        = 8'($urandom);
    bus.b        = 8'($urandom);
    bus.carry_in = 1'($urandom);
    bus.shamt    = 4'($urandom);
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      chk("in_ready_busy", bus.in_ready, 0);
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, elat);
    chk("result", bus.result, e1.res);
    chk("carry", bus.carry, e1.c);
    chk("half_carry", bus.half_carry, e1.hc);
    chk("overflow", bus.overflow, e1.v);
    chk("zero", bus.zero, e1.z);
    chk("negative", bus.negative, e1.ng);
    chk("bin_valid", bbus.out_valid, 1);
    chk("bin_result", bbus.result, e0.res);
    chk("bin_carry", bbus.carry, e0.c);
    chk("bin_half_carry", bbus.half_carry, e0.hc);
    chk("bin_overflow", bbus.overflow, e0.v);
    repeat (dly) begin
      @(posedge clk); #1;
      chk("hold_valid", bus.out_valid, 1);
      chk("hold_result", bus.result, e1.res);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("drop_valid", bus.out_valid, 0);
    chk("back_idle", bus.in_ready, 1);
    chk("result_kept", bus.result, e1.res);
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.op = 3'd0;
    bus.a = 8'd0; bus.b = 8'd0; bus.carry_in = 1'b0; bus.shamt = 4'd0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_result", bus.result, 0);
    chk("rst_flags", {bus.carry, bus.half_carry, bus.overflow, bus.zero, bus.negative}, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    rst = 1'b0;

    // ADD with signed overflow.
    transact(0, 8'h50, 8'h50, 0, 0, 0);
    chk("add_result", bus.result, 8'hA0);
    chk("add_flags", {bus.carry, bus.half_carry, bus.overflow, bus.negative, bus.zero}, 5'b00110);

    // DADD in both decimal and binary instances.
    transact(6, 8'h58, 8'h46, 1, 0, 1);
    chk("dadd_result", bus.result, 8'h05);
    chk("dadd_flags", {bus.carry, bus.half_carry, bus.overflow}, 3'b110);
    chk("dadd_bin_result", bbus.result, 8'h9F);
    chk("dadd_bin_carry", bbus.carry, 0);

    // SR by 3 with intermediate values visible, fill latched at accept.
    @(negedge clk);
    bus.in_valid = 1'b1; bus.op = 3'd4; bus.a = 8'h81; bus.carry_in = 1'b1; bus.shamt = 4'd3;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.carry_in = 1'b0;
    chk("sr_load", bus.result, 8'h81);
    chk("sr_busy0", {bus.in_ready, bus.out_valid}, 2'b00);
    @(posedge clk); #1;
    chk("sr_step1", bus.result, 8'hC0);
    chk("sr_busy1", {bus.in_ready, bus.out_valid}, 2'b00);
    @(posedge clk); #1;
    chk("sr_step2", bus.result, 8'hE0);
    chk("sr_busy2", {bus.in_ready, bus.out_valid}, 2'b00);
    @(posedge clk); #1;
    chk("sr_final", bus.result, 8'hF0);
    chk("sr_valid", {bus.in_ready, bus.out_valid}, 2'b01);
    chk("sr_flags", {bus.carry, bus.negative, bus.zero, bus.half_carry, bus.overflow}, 5'b01000);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("sr_idle", bus.in_ready, 1);

    // SUB with borrow and SL out of the MSB.
    transact(7, 8'h10, 8'h20, 1, 0, 0);
    chk("sub_result", bus.result, 8'hF0);
    chk("sub_flags", {bus.carry, bus.overflow, bus.negative}, 3'b001);
    transact(5, 8'h80, 0, 0, 1, 0);
    chk("sl_result", bus.result, 8'h00);
    chk("sl_flags", {bus.carry, bus.zero}, 2'b11);

    // Backpressure with in_valid pulsing; no second accept.
    @(negedge clk);
    bus.in_valid = 1'b1; bus.op = 3'd1; bus.a = 8'hF0; bus.b = 8'h3C; bus.carry_in = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = i[0];
      bus.op = 3'd0;
      bus.a = 8'($urandom);
      chk("bp_result", bus.result, 8'h30);
      chk("bp_valid", {bus.out_valid, bus.in_ready}, 2'b10);
      @(posedge clk); #1;
    end
    chk("bp_result_end", bus.result, 8'h30);
    chk("bp_and_flags", {bus.carry, bus.half_carry, bus.overflow}, 3'b000);
    bus.in_valid = 1'b1; bus.a = 8'h01; bus.b = 8'h01; bus.carry_in = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0; bus.in_valid = 1'b0;
    chk("bp_release", {bus.out_valid, bus.in_ready}, 2'b01);
    chk("bp_no_accept_result", bus.result, 8'h30);
    @(posedge clk); #1;
    chk("bp_still_idle", {bus.out_valid, bus.in_ready}, 2'b01);

    // Reset in the middle of an 8-bit shift.
    @(negedge clk);
    bus.in_valid = 1'b1; bus.op = 3'd4; bus.a = 8'hA5; bus.carry_in = 1'b1; bus.shamt = 4'd8;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_result", bus.result, 0);
    chk("mid_rst_flags", {bus.carry, bus.half_carry, bus.overflow, bus.zero, bus.negative}, 0);
    chk("mid_rst_hs", {bus.out_valid, bus.in_ready}, 2'b01);
    chk("mid_rst_bin", {bbus.result, bbus.out_valid, bbus.in_ready}, 10'b0000000001);
    transact(0, 8'h01, 8'h01, 0, 0, 0);
    chk("post_rst_add", bus.result, 8'h02);

    // Random operations, shift counts including clamped values, random backpressure.
    for (int k = 0; k < 60; k++) begin
      transact(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
               int'($urandom_range(0, 1)), int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked, sequential successor to the combinational 6502 ALU.
- Generalises width in nibble multiples and decimal adjust across all nibbles.
- Adds subtract, left shift and multi-bit shifts executed one bit per clock.
- Sits between the register file/operand latches and the flag/accumulator writeback. Results and flags are registered and held until consumed.

Parameters:
- WIDTH, 8, datapath width in bits; multiple of 4, range 8..32.
- DECIMAL, 1, 1 enables the DADD op; 0 makes DADD behave as ADD.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept; high only in IDLE.
- op  in  3  000 ADD, 001 AND, 010 OR, 011 EOR, 100 SR, 101 SL, 110 DADD, 111 SUB.
- a  in  WIDTH  operand A; the shift source.
- b  in  WIDTH  operand B.
- carry_in  in  1  adder carry-in; shift fill bit.
- shamt  in  $clog2(WIDTH+1)  shift count; values above WIDTH clamp to WIDTH.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  registered result.
- carry  out  1  carry out of the MSB (ADD/DADD/SUB), or last bit shifted out.
- half_carry  out  1  carry from nibble 0 into nibble 1, after decimal adjust.
- overflow  out  1  signed overflow.
- zero  out  1  result == 0.
- negative  out  1  result[WIDTH-1].

Behaviour:
- States: IDLE, SHIFT, DONE. Only the inputs sampled at the accept edge matter; later input changes are ignored.
- Reset: state=IDLE. result, carry, half_carry, overflow, zero, negative and out_valid all 0. in_ready=1 (combinational from state).
- Accept: in_valid & in_ready at a rising edge.
- Accept, ops ADD/AND/OR/EOR/DADD/SUB, or shifts with effective shamt==0: compute and register result and flags at that edge, go to DONE. out_valid is high 1 cycle after accept.
- Accept, SR/SL with effective shamt>0: load a into result and the count into a counter, go to SHIFT.
- SHIFT: one step per edge.
  - SR: result={carry_in, result[WIDTH-1:1]}, carry=result[0].
  - SL: result={result[WIDTH-2:0], carry_in}, carry=result[WIDTH-1].
  - After the step that brings the counter to 0, update zero/negative and go to DONE. out_valid is high shamt+1 cycles after accept.
  - Shifts force half_carry=0 and overflow=0.
  - shamt==0 shift: result=a, carry=carry_in.
- ADD: {carry,result}=a+b+carry_in. overflow=(a[MSB]==b[MSB]) & (result[MSB]!=a[MSB]).
- SUB: identical to ADD with b replaced by ~b. carry=1 means no borrow.
- DADD: for each nibble i from LSB, s=a_i+b_i+c_i. If s>9, digit=(s+6) mod 16 and c_{i+1}=1; else digit=s and c_{i+1}=0. carry=c_out of the top nibble. Non-BCD nibbles follow the same rule, with no error flag. overflow=0.
- AND/OR/EOR: carry, half_carry and overflow all 0.
- zero and negative are valid for every op.
- DONE: outputs held stable while out_ready=0. On out_valid & out_ready go to IDLE. out_valid drops next cycle; result and flags keep their values. No accept in the same cycle as the DONE handshake.
- in_valid while not in_ready is ignored (not queued).
- rst in any state, including mid-SHIFT or DONE: next edge gives reset values. The in-flight op is discarded.

Test Plan:
- WIDTH=8, ADD a=0x50 b=0x50 cin=0 -> result 0xA0, carry 0, half_carry 0, overflow 1, negative 1, zero 0; out_valid exactly 1 cycle after accept.
- DADD a=0x58 b=0x46 cin=1 -> result 0x05, carry 1, half_carry 1, overflow 0. Repeat with DECIMAL=0 -> result 0x9F, carry 0.
- SR a=0x81 shamt=3 cin=1 -> result 0xF0, carry 0, negative 1. Intermediate values 0xC0, 0xE0. out_valid 4 cycles after accept; in_ready 0 throughout.
- SUB a=0x10 b=0x20 cin=1 -> result 0xF0, carry 0, overflow 0, negative 1. SL a=0x80 shamt=1 cin=0 -> result 0x00, carry 1, zero 1.
- Backpressure: hold out_ready=0 for 5 cycles after an AND a=0xF0 b=0x3C with in_valid pulsing -> result 0x30 stable, no second accept. Raise out_ready -> IDLE next cycle.
- Assert rst during the second SHIFT cycle of SR shamt=8 -> next cycle all outputs 0, in_ready 1. A subsequent ADD 0x01+0x01 gives 0x02.
